decode_stage: RTL and testbench

Registered RV32I/RV64I instruction decode stage between fetch and execute. It replaces the purely combinational field splitter with three additions:
- a valid/ready pipeline slot with a skid buffer;
- a single format-selected, XLEN-wide sign-extended immediate;
- PC passthrough, flush, and optional illegal-instruction detection.

---
 rtl/decode_pkg.sv | 66 ++++++
 rtl/decode_stage_if.sv | 33 +++
 rtl/decode_stage_imm_gen.sv | 47 ++++
 rtl/decode_stage.sv | 121 ++++++++++++
 tb/tb_decode_stage.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_pkg.sv
// Shared definitions for the instruction decode stage: opcode constants,
// the immediate-format enum, the XLEN-independent decoded fields and the
// illegal-instruction classifier used when DECODE_ILLEGAL_CHECK_EN is defined.
package decode_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } imm_fmt_e;

    // Register-index and opcode fields of a bundle. The XLEN-wide imm/pc
    // fields are added by decode_stage, since a package cannot be parametrised.
    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        imm_fmt_e   imm_fmt;
        logic       illegal;
    } decode_fields_t;

    // Classify an instruction word as illegal; rv64 widens shamt to 6 bits,
    // so only instr[31:26] must be zero / 010000 for the shift immediates.
    function automatic logic is_illegal(input logic [31:0] instr, input logic rv64);
        logic [6:0] f7;
        logic [5:0] f6;
        logic [2:0] f3;
        logic       hi_zero;
        logic       hi_sra;
        logic       bad;
        f7      = instr[31:25];
        f6      = instr[31:26];
        f3      = instr[14:12];
        hi_zero = rv64 ? (f6 == 6'b000000) : (f7 == 7'b0000000);
        hi_sra  = rv64 ? (f6 == 6'b010000) : (f7 == 7'b0100000);
        case (instr[6:0])
            OPC_OP: bad = ((f7 != 7'b0000000) && (f7 != 7'b0100000)) ||
                          ((f7 == 7'b0100000) && (f3 != 3'b000) && (f3 != 3'b101));
            OPC_OP_IMM: bad = ((f3 == 3'b001) && !hi_zero) ||
                              ((f3 == 3'b101) && !hi_zero && !hi_sra);
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD,
            OPC_MISC_MEM, OPC_SYSTEM, OPC_BRANCH, OPC_STORE: bad = 1'b0;
            default: bad = 1'b1;
        endcase
        return bad || (instr[1:0] != 2'b11);
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake/bus signals of decode_stage.
// slave: the decode stage itself; master: whoever drives it (fetch + execute).
interface decode_stage_if #(parameter int XLEN = 32);
    logic            flush_i;
    logic            in_valid_i;
    logic            in_ready_o;
    logic [31:0]     instr_i;
    logic [XLEN-1:0] pc_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [6:0]      opcode_o;
    logic [2:0]      funct3_o;
    logic [6:0]      funct7_o;
    logic [4:0]      rd_o;
    logic [4:0]      rs1_o;
    logic [4:0]      rs2_o;
    logic [XLEN-1:0] imm_o;
    logic [2:0]      imm_fmt_o;
    logic [XLEN-1:0] pc_o;
    logic            illegal_o;

    modport slave (
        input  flush_i, in_valid_i, instr_i, pc_i, out_ready_i,
        output in_ready_o, out_valid_o, opcode_o, funct3_o, funct7_o,
               rd_o, rs1_o, rs2_o, imm_o, imm_fmt_o, pc_o, illegal_o
    );

    modport master (
        output flush_i, in_valid_i, instr_i, pc_i, out_ready_i,
        input  in_ready_o, out_valid_o, opcode_o, funct3_o, funct7_o,
               rd_o, rs1_o, rs2_o, imm_o, imm_fmt_o, pc_o, illegal_o
    );
endinterface

// File: rtl/decode_stage_imm_gen.sv
// imm_gen: opcode -> immediate format, and the matching immediate
// sign-extended from instr[31] to XLEN bits. Purely combinational.
module imm_gen
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output imm_fmt_e        imm_fmt_o,
    output logic [XLEN-1:0] imm_o
);
    typedef logic [XLEN-1:0] xlen_t;

    // Pick the format from the opcode and assemble its immediate
    always_comb begin
        imm_fmt_o = FMT_R;
        imm_o     = {XLEN{1'b0}};
        case (instr_i[6:0])
            OPC_LUI, OPC_AUIPC: begin
                imm_fmt_o = FMT_U;
                imm_o     = xlen_t'($signed({instr_i[31:12], 12'h000}));
            end
            OPC_JAL: begin
                imm_fmt_o = FMT_J;
                imm_o     = xlen_t'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                                             instr_i[30:21], 1'b0}));
            end
            OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_MISC_MEM, OPC_SYSTEM: begin
                imm_fmt_o = FMT_I;
                imm_o     = xlen_t'($signed(instr_i[31:20]));
            end
            OPC_BRANCH: begin
                imm_fmt_o = FMT_B;
                imm_o     = xlen_t'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                                             instr_i[11:8], 1'b0}));
            end
            OPC_STORE: begin
                imm_fmt_o = FMT_S;
                imm_o     = xlen_t'($signed({instr_i[31:25], instr_i[11:7]}));
            end
            default: begin
                imm_fmt_o = FMT_R;
                imm_o     = {XLEN{1'b0}};
            end
        endcase
    end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I/RV64I decode between fetch and execute.
// One output slot drives every output; a skid slot absorbs the single word
// accepted while the output is stalled, so in_ready_o can be a register.
// Optional feature: define DECODE_ILLEGAL_CHECK_EN to enable illegal_o;
// otherwise illegal_o is tied to 0 and no check logic is built.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input logic          clk_i,
    input logic          rst_ni,
    decode_stage_if.slave bus
);
    typedef struct packed {
        decode_fields_t  f;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
    } bundle_t;

    bundle_t         in_s;
    bundle_t         out_q, out_d;
    bundle_t         skid_q, skid_d;
    logic            out_valid_q, out_valid_d;
    logic            skid_valid_q, skid_valid_d;
    logic            in_ready_q, in_ready_d;
    logic            accept_s;
    logic            illegal_s;
    imm_fmt_e        fmt_s;
    logic [XLEN-1:0] imm_s;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr_i   (bus.instr_i),
        .imm_fmt_o (fmt_s),
        .imm_o     (imm_s)
    );

`ifdef DECODE_ILLEGAL_CHECK_EN
    assign illegal_s = is_illegal(bus.instr_i, (XLEN == 64));
`else
    assign illegal_s = 1'b0;
`endif

    assign accept_s = bus.in_valid_i & in_ready_q;

    // Decode the incoming word into a full bundle
    always_comb begin
        in_s.f.opcode  = bus.instr_i[6:0];
        in_s.f.funct3  = bus.instr_i[14:12];
        in_s.f.funct7  = bus.instr_i[31:25];
        in_s.f.rd      = bus.instr_i[11:7];
        in_s.f.rs1     = bus.instr_i[19:15];
        in_s.f.rs2     = bus.instr_i[24:20];
        in_s.f.imm_fmt = fmt_s;
        in_s.f.illegal = illegal_s;
        in_s.imm       = imm_s;
        in_s.pc        = bus.pc_i;
    end

    // Slot transfers: flush first, then drain/refill, else park in skid
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (bus.flush_i) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || bus.out_ready_i) begin
            // A full skid implies in_ready was low, so nothing is accepted here.
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept_s) begin
                out_d       = in_s;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else begin
            if (accept_s) begin
                skid_d       = in_s;
                skid_valid_d = 1'b1;
            end else begin
                skid_valid_d = skid_valid_q;
            end
        end
        in_ready_d = ~skid_valid_d;
    end

    // Slot and handshake registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign bus.in_ready_o  = in_ready_q;
    assign bus.out_valid_o = out_valid_q;
    assign bus.opcode_o    = out_q.f.opcode;
    assign bus.funct3_o    = out_q.f.funct3;
    assign bus.funct7_o    = out_q.f.funct7;
    assign bus.rd_o        = out_q.f.rd;
    assign bus.rs1_o       = out_q.f.rs1;
    assign bus.rs2_o       = out_q.f.rs2;
    assign bus.imm_o       = out_q.imm;
    assign bus.imm_fmt_o   = out_q.f.imm_fmt;
    assign bus.pc_o        = out_q.pc;
    assign bus.illegal_o   = out_q.f.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed vectors plus a random stream checked
// against a two-entry in-order queue model of the stage.
module tb_decode_stage;
    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  fmt;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        illegal;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q[$];
    logic [6:0] opcs [12] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13,
                              7'h0F, 7'h73, 7'h63, 7'h23, 7'h33, 7'h00};

    always #5 clk = ~clk;

    decode_stage_if #(.XLEN(32)) bus32();
    decode_stage_if #(.XLEN(64)) bus64();

    decode_stage #(.XLEN(32)) dut32 (.clk_i(clk), .rst_ni(rst_n), .bus(bus32));
    decode_stage #(.XLEN(64)) dut64 (.clk_i(clk), .rst_ni(rst_n), .bus(bus64));

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, required finish");
        $fatal(1);
    end

    function automatic exp_t obs32();
        exp_t o;
        o.opcode  = bus32.opcode_o;
        o.funct3  = bus32.funct3_o;
        o.funct7  = bus32.funct7_o;
        o.rd      = bus32.rd_o;
        o.rs1     = bus32.rs1_o;
        o.rs2     = bus32.rs2_o;
        o.fmt     = bus32.imm_fmt_o;
        o.imm     = bus32.imm_o;
        o.pc      = bus32.pc_o;
        o.illegal = bus32.illegal_o;
        return o;
    endfunction

    function automatic logic [2:0] ref_fmt(logic [6:0] opc);
        if (opc inside {7'h37, 7'h17}) return 3'd4;
        else if (opc == 7'h6F) return 3'd5;
        else if (opc inside {7'h67, 7'h03, 7'h13, 7'h0F, 7'h73}) return 3'd1;
        else if (opc == 7'h63) return 3'd3;
        else if (opc == 7'h23) return 3'd2;
        else return 3'd0;
    endfunction

    // Immediate as a signed integer: sign bit carries negative weight.
    function automatic longint ref_imm(logic [31:0] ins, logic [2:0] fmt);
        longint s;
        s = longint'(ins[31]);
        case (fmt)
            3'd1: return longint'(ins[31:20]) - s * 4096;
            3'd2: return longint'(ins[31:25]) * 32 + longint'(ins[11:7]) - s * 4096;
            3'd3: return longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32
                         + longint'(ins[11:8]) * 2 - s * 4096;
            3'd4: return longint'(ins[31:12]) * 4096 - s * 64'sd4294967296;
            3'd5: return longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048
                         + longint'(ins[30:21]) * 2 - s * 1048576;
            default: return 64'sd0;
        endcase
    endfunction

    function automatic logic ref_illegal(logic [31:0] ins);
`ifdef DECODE_ILLEGAL_CHECK_EN
        logic bad;
        logic [6:0] f7;
        logic [2:0] f3;
        f7  = ins[31:25];
        f3  = ins[14:12];
        bad = (ins[1:0] != 2'b11) ||
              !(ins[6:0] inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13,
                                 7'h0F, 7'h73, 7'h63, 7'h23, 7'h33});
        if (ins[6:0] == 7'h33)
            bad = bad || !(f7 inside {7'h00, 7'h20}) || (f7 == 7'h20 && !(f3 inside {3'd0, 3'd5}));
        if (ins[6:0] == 7'h13 && f3 == 3'd1) bad = bad || (f7 != 7'h00);
        if (ins[6:0] == 7'h13 && f3 == 3'd5) bad = bad || !(f7 inside {7'h00, 7'h20});
        return bad;
`else
        return ins[0] & 1'b0;
`endif
    endfunction

    function automatic exp_t ref_decode(logic [31:0] ins, logic [31:0] pc);
        exp_t   e;
        longint v;
        e.opcode  = ins[6:0];
        e.funct3  = ins[14:12];
        e.funct7  = ins[31:25];
        e.rd      = ins[11:7];
        e.rs1     = ins[19:15];
        e.rs2     = ins[24:20];
        e.fmt     = ref_fmt(ins[6:0]);
        v         = ref_imm(ins, e.fmt);
        e.imm     = v[31:0];
        e.pc      = pc;
        e.illegal = ref_illegal(ins);
        return e;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] ins;
        int k;
        ins = $urandom;
        k   = $urandom_range(0, 11);
        if (k != 11) ins[6:0] = opcs[k];
        if ($urandom_range(0, 1) == 1) ins[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return ins;
    endfunction

    // Present inputs for the next edge, advance the queue model, wait for the next negedge.
    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic rdy, input logic fl);
        logic acc, pop;
        bus32.in_valid_i  = v;
        bus32.instr_i     = ins;
        bus32.pc_i        = pc;
        bus32.out_ready_i = rdy;
        bus32.flush_i     = fl;
        acc = v && !fl && (q.size() < 2);
        pop = (q.size() > 0) && rdy;
        if (fl) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(ref_decode(ins, pc));
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        n_cmp++; if (bus32.out_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %0b want 0", bus32.out_valid_o); end
        n_cmp++; if (bus32.in_ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %0b want 1", bus32.in_ready_o); end
        n_cmp++; if (obs32() !== '0) begin n_bad++; $display("FAIL reset_data got %h want 0", obs32()); end
        rst_n = 1'b1;
        q.delete();
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [31:0] ins [3] = '{32'hFFF00093, 32'hFE000EE3, 32'h123452B7};
        logic [31:0] pcs [3] = '{32'h100, 32'h104, 32'h108};
        logic [4:0]  rds [3] = '{5'd1, 5'd29, 5'd5};
        logic [2:0]  fmt [3] = '{3'd1, 3'd3, 3'd4};
        logic [31:0] imm [3] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h12345000};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ins[i], pcs[i], 1'b1, 1'b0);
            n_cmp++; if (bus32.out_valid_o !== 1'b1) begin n_bad++; $display("FAIL dir%0d_valid got %0b want 1", i, bus32.out_valid_o); end
            n_cmp++; if (bus32.rd_o !== rds[i]) begin n_bad++; $display("FAIL dir%0d_rd got %0d want %0d", i, bus32.rd_o, rds[i]); end
            n_cmp++; if (bus32.imm_fmt_o !== fmt[i]) begin n_bad++; $display("FAIL dir%0d_fmt got %0d want %0d", i, bus32.imm_fmt_o, fmt[i]); end
            n_cmp++; if (bus32.imm_o !== imm[i]) begin n_bad++; $display("FAIL dir%0d_imm got %h want %h", i, bus32.imm_o, imm[i]); end
            n_cmp++; if (bus32.pc_o !== pcs[i]) begin n_bad++; $display("FAIL dir%0d_pc got %h want %h", i, bus32.pc_o, pcs[i]); end
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_xlen64();
        bus64.in_valid_i = 1'b1;
        bus64.instr_i    = 32'h800002B7;
        bus64.pc_i       = 64'h200;
        @(negedge clk);
        bus64.in_valid_i = 1'b0;
        n_cmp++; if (bus64.out_valid_o !== 1'b1) begin n_bad++; $display("FAIL x64_valid got %0b want 1", bus64.out_valid_o); end
        n_cmp++; if (bus64.imm_o !== 64'hFFFFFFFF80000000) begin n_bad++; $display("FAIL x64_imm got %h want ffffffff80000000", bus64.imm_o); end
        n_cmp++; if (bus64.imm_fmt_o !== 3'd4 || bus64.pc_o !== 64'h200) begin n_bad++; $display("FAIL x64_fmt_pc got %0d/%h want 4/200", bus64.imm_fmt_o, bus64.pc_o); end
        @(negedge clk);
    endtask

    task automatic test_skid_order();
        logic [31:0] w [4];
        logic [31:0] p [4];
        logic [31:0] got[$];
        int idx = 0;
        logic rdy, acc;
        for (int i = 0; i < 4; i++) begin w[i] = gen_instr(); p[i] = 32'h1000 + 32'(i * 4); end
        for (int cyc = 0; cyc < 12; cyc++) begin
            n_cmp++;
            if (bus32.out_valid_o !== (q.size() > 0) || bus32.in_ready_o !== (q.size() < 2)) begin
                n_bad++; $display("FAIL skid_hs cyc%0d got v=%0b r=%0b want v=%0b r=%0b", cyc,
                                  bus32.out_valid_o, bus32.in_ready_o, q.size() > 0, q.size() < 2);
            end
            if (q.size() > 0) begin
                n_cmp++; if (obs32() !== q[0]) begin n_bad++; $display("FAIL skid_data cyc%0d got %h want %h", cyc, obs32(), q[0]); end
            end
            rdy = (cyc >= 4);
            if (bus32.out_valid_o && rdy) got.push_back(bus32.pc_o);
            acc = (idx < 4) && (q.size() < 2);
            drive(idx < 4, w[idx % 4], p[idx % 4], rdy, 1'b0);
            if (acc) idx++;
        end
        n_cmp++; if (got.size() != 4) begin n_bad++; $display("FAIL skid_count got %0d want 4", got.size()); end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            n_cmp++; if (got[i] !== p[i]) begin n_bad++; $display("FAIL skid_order%0d got %h want %h", i, got[i], p[i]); end
        end
    endtask

    task automatic test_flush();
        drive(1'b1, gen_instr(), 32'h2000, 1'b0, 1'b0);
        drive(1'b1, gen_instr(), 32'h2004, 1'b0, 1'b0);
        n_cmp++; if (bus32.in_ready_o !== 1'b0) begin n_bad++; $display("FAIL flush_full got ready=%0b want 0", bus32.in_ready_o); end
        drive(1'b1, gen_instr(), 32'h2008, 1'b0, 1'b1);
        n_cmp++; if (bus32.out_valid_o !== 1'b0) begin n_bad++; $display("FAIL flush_valid got %0b want 0", bus32.out_valid_o); end
        n_cmp++; if (bus32.in_ready_o !== 1'b1) begin n_bad++; $display("FAIL flush_ready got %0b want 1", bus32.in_ready_o); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            n_cmp++; if (bus32.out_valid_o !== 1'b0) begin n_bad++; $display("FAIL flush_ghost%0d got valid=%0b want 0", i, bus32.out_valid_o); end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] ins [3] = '{32'h40001033, 32'h00000000, 32'h40000033};
`ifdef DECODE_ILLEGAL_CHECK_EN
        logic        ill [3] = '{1'b1, 1'b1, 1'b0};
`else
        logic        ill [3] = '{1'b0, 1'b0, 1'b0};
`endif
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ins[i], 32'h300, 1'b1, 1'b0);
            n_cmp++; if (bus32.illegal_o !== ill[i] || bus32.out_valid_o !== 1'b1) begin
                n_bad++; $display("FAIL illegal%0d got %0b want %0b", i, bus32.illegal_o, ill[i]);
            end
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            n_cmp++;
            if (bus32.out_valid_o !== (q.size() > 0) || bus32.in_ready_o !== (q.size() < 2)) begin
                n_bad++; $display("FAIL rand_hs cyc%0d got v=%0b r=%0b want v=%0b r=%0b", cyc,
                                  bus32.out_valid_o, bus32.in_ready_o, q.size() > 0, q.size() < 2);
            end
            if (q.size() > 0) begin
                n_cmp++; if (obs32() !== q[0]) begin n_bad++; $display("FAIL rand_data cyc%0d got %h want %h", cyc, obs32(), q[0]); end
            end
            drive($urandom_range(0, 3) != 0, gen_instr(), $urandom, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 19) == 0);
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, gen_instr(), 32'h4000, 1'b0, 1'b0);
        drive(1'b1, gen_instr(), 32'h4004, 1'b0, 1'b0);
        bus32.in_valid_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus32.out_valid_o !== 1'b0) begin n_bad++; $display("FAIL arst_valid got %0b want 0", bus32.out_valid_o); end
        n_cmp++; if (bus32.in_ready_o !== 1'b1) begin n_bad++; $display("FAIL arst_ready got %0b want 1", bus32.in_ready_o); end
        n_cmp++; if (obs32() !== '0) begin n_bad++; $display("FAIL arst_data got %h want 0", obs32()); end
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        @(negedge clk);
    endtask

    initial begin
        bus32.flush_i = 1'b0; bus32.in_valid_i = 1'b0; bus32.instr_i = 32'h0;
        bus32.pc_i = 32'h0; bus32.out_ready_i = 1'b1;
        bus64.flush_i = 1'b0; bus64.in_valid_i = 1'b0; bus64.instr_i = 32'h0;
        bus64.pc_i = 64'h0; bus64.out_ready_i = 1'b1;
        test_reset();
        test_directed();
        test_xlen64();
        test_skid_order();
        test_flush();
        test_illegal();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
